// File: rtl/adder_error_monitor.sv
// Error-statistics collector for approximate adders: exact-sum recompute, error distance, saturating run stats (ED^2 sum with ADDER_ERR_SQ_EN).
// Latency: a sample accepted at edge E is reflected in the statistics after edge E+2; done pulses in the cycle after last accept + 2 edges.
// Backpressure: in_ready is high only in RUN while fewer than num_samples have been accepted; no stalls inside the pipeline.
module adder_error_monitor #(
    parameter int N     = 16,
    parameter int CNT_W = 32,
    parameter int ACC_W = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic [N-1:0]     approx_sum,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ACC_W-1:0] ed_sum,
    output logic [N-1:0]     ed_max,
    output logic             sat
`ifdef ADDER_ERR_SQ_EN
    ,
    output logic [2*ACC_W-1:0] sq_sum
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] accepted_q, accepted_d;
    logic             done_q, done_d;

    logic             s1_vld_q;
    logic [N-1:0]     s1_exact_q, s1_approx_q;
    logic             s2_vld_q;
    logic [N-1:0]     s2_ed_q;
    logic [N-1:0]     exact_c, ed_c;

    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [ACC_W-1:0] ed_sum_q, ed_sum_d;
    logic [N-1:0]     ed_max_q, ed_max_d;
    logic             sat_q, sat_d;
    logic [CNT_W:0]   cnt_ext, err_ext;
    logic [ACC_W:0]   sum_ext;

    logic             hs;
    logic             clear;

    assign in_ready = (state_q == RUN) && (accepted_q < target_q);
    assign hs       = in_valid && in_ready;
    assign busy     = (state_q != IDLE);
    assign clear    = (state_q == IDLE) && start;

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        accepted_d = accepted_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    target_d   = num_samples;
                    accepted_d = '0;
                end
            end
            RUN: begin
                if (hs) begin
                    accepted_d = accepted_q + CNT_W'(1);
                end
                if ((target_q == '0) || (hs && (accepted_d == target_q))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Stage 2 still holds the last sample here; it accumulates on this same edge.
                if (!s1_vld_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            target_q   <= '0;
            accepted_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            accepted_q <= accepted_d;
            done_q     <= done_d;
        end
    end

    assign exact_c = a + b;
    assign ed_c    = (s1_exact_q >= s1_approx_q) ? (s1_exact_q - s1_approx_q)
                                                 : (s1_approx_q - s1_exact_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q    <= 1'b0;
            s1_exact_q  <= '0;
            s1_approx_q <= '0;
            s2_vld_q    <= 1'b0;
            s2_ed_q     <= '0;
        end else begin
            s1_vld_q <= hs;
            if (hs) begin
                s1_exact_q  <= exact_c;
                s1_approx_q <= approx_sum;
            end
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_ed_q <= ed_c;
            end
        end
    end

    // One guard bit per accumulator detects overflow; the result then clamps to all-ones.
    assign cnt_ext = {1'b0, sample_cnt_q} + (CNT_W+1)'(1);
    assign err_ext = {1'b0, err_cnt_q} + (CNT_W+1)'(s2_ed_q != '0);
    assign sum_ext = {1'b0, ed_sum_q} + (ACC_W+1)'(s2_ed_q);

`ifdef ADDER_ERR_SQ_EN
    logic [2*ACC_W-1:0] sq_sum_q, sq_sum_d;
    logic [2*N-1:0]     ed_sq;
    logic [2*ACC_W:0]   sq_ext;

    assign ed_sq  = s2_ed_q * s2_ed_q;
    assign sq_ext = {1'b0, sq_sum_q} + (2*ACC_W+1)'(ed_sq);
    assign sq_sum = sq_sum_q;
`endif

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        ed_sum_d     = ed_sum_q;
        ed_max_d     = ed_max_q;
        sat_d        = sat_q;
`ifdef ADDER_ERR_SQ_EN
        sq_sum_d     = sq_sum_q;
`endif
        if (clear) begin
            sample_cnt_d = '0;
            err_cnt_d    = '0;
            ed_sum_d     = '0;
            ed_max_d     = '0;
            sat_d        = 1'b0;
`ifdef ADDER_ERR_SQ_EN
            sq_sum_d     = '0;
`endif
        end else if (s2_vld_q) begin
            sample_cnt_d = cnt_ext[CNT_W] ? {CNT_W{1'b1}} : cnt_ext[CNT_W-1:0];
            err_cnt_d    = err_ext[CNT_W] ? {CNT_W{1'b1}} : err_ext[CNT_W-1:0];
            ed_sum_d     = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
            ed_max_d     = (s2_ed_q > ed_max_q) ? s2_ed_q : ed_max_q;
            sat_d        = sat_q | cnt_ext[CNT_W] | err_ext[CNT_W] | sum_ext[ACC_W];
`ifdef ADDER_ERR_SQ_EN
            sq_sum_d     = sq_ext[2*ACC_W] ? {(2*ACC_W){1'b1}} : sq_ext[2*ACC_W-1:0];
            sat_d        = sat_d | sq_ext[2*ACC_W];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            ed_sum_q     <= '0;
            ed_max_q     <= '0;
            sat_q        <= 1'b0;
`ifdef ADDER_ERR_SQ_EN
            sq_sum_q     <= '0;
`endif
        end else begin
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            ed_sum_q     <= ed_sum_d;
            ed_max_q     <= ed_max_d;
            sat_q        <= sat_d;
`ifdef ADDER_ERR_SQ_EN
            sq_sum_q     <= sq_sum_d;
`endif
        end
    end

    assign done       = done_q;
    assign sample_cnt = sample_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign ed_sum     = ed_sum_q;
    assign ed_max     = ed_max_q;
    assign sat        = sat_q;

endmodule

// File: tb/tb_adder_error_monitor.sv
// Bench for adder_error_monitor: directed and random runs scored against a queue of expected end-of-run statistics.
module tb_adder_error_monitor;
    localparam int N     = 16;
    localparam int CNT_W = 32;
    localparam int ACC_W = 17;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_samples = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N-1:0]     a = '0, b = '0, approx_sum = '0;
    logic             busy, done, sat;
    logic [CNT_W-1:0] sample_cnt, err_cnt;
    logic [ACC_W-1:0] ed_sum;
    logic [N-1:0]     ed_max;
`ifdef ADDER_ERR_SQ_EN
    logic [2*ACC_W-1:0] sq_sum;
`endif

    adder_error_monitor #(.N(N), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .approx_sum(approx_sum),
        .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
        .ed_sum(ed_sum), .ed_max(ed_max), .sat(sat)
`ifdef ADDER_ERR_SQ_EN
        , .sq_sum(sq_sum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        longint sc, ec, es, em, sq;
        bit     st;
        int     cyc;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    logic [N-1:0] sa[$], sbv[$], sp[$];
    int           n_chk = 0, n_fail = 0, cyc = 0, done_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Reference: statistics from the list of accepted samples, plain integer arithmetic.
    function automatic exp_t model(input logic [N-1:0] qa[$], input logic [N-1:0] qb[$],
                                   input logic [N-1:0] qp[$], input int dcyc);
        exp_t   e;
        longint s, q, mx, ex, d, acc_max, sq_max;
        int     ec;
        s = 0; q = 0; mx = 0; ec = 0;
        for (int i = 0; i < qa.size(); i++) begin
            ex = (longint'(qa[i]) + longint'(qb[i])) % (longint'(1) << N);
            d  = ex - longint'(qp[i]);
            if (d < 0) d = -d;
            if (d != 0) ec++;
            s += d;
            q += d * d;
            if (d > mx) mx = d;
        end
        e.st    = 1'b0;
        acc_max = (longint'(1) << ACC_W) - 1;
        sq_max  = (longint'(1) << (2 * ACC_W)) - 1;
        if (s > acc_max) begin
            s    = acc_max;
            e.st = 1'b1;
        end
        if (q > sq_max) begin
            q = sq_max;
`ifdef ADDER_ERR_SQ_EN
            e.st = 1'b1;
`endif
        end
        e.sc = qa.size(); e.ec = ec; e.es = s; e.em = mx; e.sq = q; e.cyc = dcyc;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expected run.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_seen++;
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pulse", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
                chk("busy_at_done", 64'(busy), 0);
                chk("sample_cnt", 64'(sample_cnt), mon_e.sc);
                chk("err_cnt", 64'(err_cnt), mon_e.ec);
                chk("ed_sum", 64'(ed_sum), mon_e.es);
                chk("ed_max", 64'(ed_max), mon_e.em);
                chk("sat", 64'(sat), 64'(mon_e.st));
`ifdef ADDER_ERR_SQ_EN
                chk("sq_sum", 64'(sq_sum), mon_e.sq);
`endif
            end
        end
    end

    task automatic push_sample(input logic [N-1:0] va, input logic [N-1:0] vb, input logic [N-1:0] vp);
        sa.push_back(va); sbv.push_back(vb); sp.push_back(vp);
    endtask

    task automatic flush_samples();
        sa.delete(); sbv.delete(); sp.delete();
    endtask

    // Called at a negedge; returns at a negedge with the DUT idle again.
    task automatic run(input int n, input int gap_pct, input bit hold_start);
        logic [N-1:0] ma[$], mb[$], mp[$];
        int   acc, s_edge, last, budget, seen0;
        exp_t e;
        acc = 0;
        start = 1'b1;
        num_samples = CNT_W'(n);
        s_edge = cyc + 1;
        last = s_edge;
        @(negedge clk);
        start = hold_start;
        if (hold_start) num_samples = CNT_W'(5);
        chk("busy_after_start", 64'(busy), 1);
        chk("sample_cnt_cleared", 64'(sample_cnt), 0);
        chk("err_cnt_cleared", 64'(err_cnt), 0);
        chk("ed_sum_cleared", 64'(ed_sum), 0);
        chk("ed_max_cleared", 64'(ed_max), 0);
        chk("sat_cleared", 64'(sat), 0);
        budget = 0;
        while (acc < n && budget < 400) begin
            chk("in_ready_run", 64'(in_ready), 1);
            in_valid = ($urandom_range(99) >= 32'(gap_pct)) && (sa.size() > 0);
            if (in_valid) begin
                a = sa[0]; b = sbv[0]; approx_sum = sp[0];
                ma.push_back(sa.pop_front());
                mb.push_back(sbv.pop_front());
                mp.push_back(sp.pop_front());
                acc++;
                last = cyc + 1;
            end
            @(negedge clk);
            budget++;
        end
        in_valid = 1'b0;
        if (acc < n) chk("accept_timeout", 64'(acc), 64'(n));
        e = model(ma, mb, mp, (n == 0) ? s_edge + 2 : last + 2);
        seen0 = done_seen;
        sb_q.push_back(e);
        for (int k = 0; k < 2; k++) begin
            chk("in_ready_after_target", 64'(in_ready), 0);
            in_valid = (sa.size() > 0);
            if (in_valid) begin
                a = sa[0]; b = sbv[0]; approx_sum = sp[0];
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        start = 1'b0;
        budget = 0;
        while (done_seen == seen0 && budget < 12) begin
            @(negedge clk);
            budget++;
        end
        if (done_seen == seen0) begin
            chk("done_timeout", 64'(done_seen), 64'(seen0 + 1));
            sb_q.delete();
        end
        @(negedge clk);
        chk("busy_idle", 64'(busy), 0);
        chk("sample_cnt_hold", 64'(sample_cnt), e.sc);
        chk("ed_sum_hold", 64'(ed_sum), e.es);
        flush_samples();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_in_ready"}, 64'(in_ready), 0);
        chk({tag, "_sample_cnt"}, 64'(sample_cnt), 0);
        chk({tag, "_err_cnt"}, 64'(err_cnt), 0);
        chk({tag, "_ed_sum"}, 64'(ed_sum), 0);
        chk({tag, "_ed_max"}, 64'(ed_max), 0);
        chk({tag, "_sat"}, 64'(sat), 0);
`ifdef ADDER_ERR_SQ_EN
        chk({tag, "_sq_sum"}, 64'(sq_sum), 0);
`endif
    endtask

    initial begin
        logic [N-1:0] ra, rb, rex, rp;
        int           n, mode;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // Exact samples, back-to-back
        push_sample(16'h1234, 16'h5678, 16'h68AC);
        push_sample(16'hAAAA, 16'h5555, 16'hFFFF);
        run(2, 0, 1'b0);

        // Error magnitudes with carry-out dropped: ED 16 and 63
        push_sample(16'hFFFF, 16'h0001, 16'h0010);
        push_sample(16'h0F0F, 16'hF0F0, 16'hFFC0);
        run(2, 0, 1'b0);

        // Zero-length run with start held through RUN and DRAIN
        run(0, 0, 1'b1);

        // Saturation of the ED sum
        repeat (3) push_sample(16'h0000, 16'h0000, 16'hFFFF);
        run(3, 0, 1'b0);

        // Back-pressure: 5 offered, 3 taken, start also clears sat
        for (int i = 0; i < 5; i++) push_sample(N'(i * 7), N'(i * 3), N'(i * 10 + 1));
        run(3, 50, 1'b0);

        // Reset mid-run after 2 of 4 samples
        start = 1'b1; num_samples = CNT_W'(4);
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; a = 16'h0001; b = 16'h0002; approx_sum = 16'h0007;
        @(negedge clk);
        a = 16'h0100; b = 16'h0200; approx_sum = 16'h0300;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all_zero("midrun_reset");
        @(negedge clk);
        rst = 1'b0;
        push_sample(16'h4321, 16'h1111, 16'h5432);
        run(1, 0, 1'b0);

        // Random runs
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(20, 1);
            for (int i = 0; i < n + 3; i++) begin
                ra = N'($urandom);
                rb = N'($urandom);
                rex = ra + rb;
                mode = $urandom_range(9, 0);
                if (mode < 5) rp = rex;
                else if (mode < 8) rp = rex ^ N'($urandom_range(255, 0));
                else rp = N'($urandom);
                push_sample(ra, rb, rp);
            end
            run(n, $urandom_range(60, 0), 1'b0);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
